reg_dump_reader: RTL
====================

# reg_dump_reader

Debug read-out sequencer for the 32x32 register file. On a start request it halts the core, walks register indices 0..WORDS-1 through the file's source-A read port, and streams each word out over a valid/ready handshake to the debug/UART path. It is the reader counterpart to the writeback path that fills the register file, and it sits between the register file's srcA mux and the debug transport.

## Interface
- DATA_WIDTH, 32: register word width
- WORDS, 32: number of registers walked
- SELECT_SIZE, 5: register select width; WORDS = 2**SELECT_SIZE
- clk_i  in  1  system clock; all state changes on rising edge
- rst_ni  in  1  reset, synchronous, active-low
- start_i  in  1  level; sampled in IDLE only
- abort_i  in  1  cancel dump; any state except IDLE
- halt_o  out  1  request core halt; owns the srcA select while high
- halted_i  in  1  core acknowledges halt
- reg_sel_o  out  SELECT_SIZE  register select to file srcA port
- reg_data_i  in  DATA_WIDTH  file srcA output, combinational from reg_sel_o
- dout_o  out  DATA_WIDTH  streamed word
- dout_idx_o  out  SELECT_SIZE+1  index of dout_o; WORDS marks checksum word
- dout_valid_o  out  1  dout_o/dout_idx_o valid
- dout_ready_i  in  1  sink accepts
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse when dump completes

## Operation
- States: IDLE, HALT, FETCH, PRESENT, CKSUM, DONE.
- IDLE: start_i=1 -> HALT; idx cleared to 0; checksum cleared.
- HALT: halt_o=1; wait for halted_i=1 -> FETCH. halted_i is sampled only here.
- FETCH: reg_sel_o=idx; at the edge, capture reg_data_i into dout_o, set dout_idx_o=idx, dout_valid_o=1 -> PRESENT.
- PRESENT: hold dout_o/dout_idx_o/dout_valid_o stable until dout_valid_o&&dout_ready_i at an edge (transfer). On transfer: add the word to the checksum, deassert valid. If idx=WORDS-1 -> CKSUM (macro on) or DONE, else idx+1 -> FETCH.
- CKSUM: dout_o=checksum, dout_idx_o=WORDS, valid until transfer -> DONE.
- DONE: done_o=1 for one cycle; halt_o drops at the same edge that leaves DONE -> IDLE.
- Register 0 is read raw. No zero forcing.
- Checksum: sum of all transferred register words modulo 2**DATA_WIDTH.
- start_i while busy: ignored. start_i held high through DONE starts a new dump from IDLE on the following cycle.
- abort_i: takes priority over all other transitions. Next edge -> IDLE, valid=0, halt_o=0, no done_o. A transfer occurring in the same cycle is discarded.
- reg_sel_o holds its last value outside FETCH/PRESENT. Its value has no meaning while halt_o=0.

## Timing
- Reset values: halt_o=0, reg_sel_o=0, dout_o=0, dout_idx_o=0, dout_valid_o=0, busy_o=0, done_o=0, state IDLE.
- start_i to halt_o: 1 cycle.
- halted_i to first dout_valid_o: 2 cycles (HALT->FETCH, FETCH->PRESENT).
- Per word: 2 cycles minimum with dout_ready_i tied high.
- With ready tied high, last transfer to done_o: 1 cycle (2 with the checksum word).
- Full dump with ready high and halted_i high: 1 + 1 + 2*WORDS + 1 cycles (+1 with checksum), start to done.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- DUMP_CHECKSUM_EN defined: the CKSUM state exists. One extra word is streamed after the last register, with dout_idx_o=WORDS.
- Not defined: CKSUM and the accumulator are removed. The last register transfer goes directly to DONE. dout_idx_o never equals WORDS.

## Structure
- reg_dump_pkg holds:
  - the state enum
  - the CKSUM_IDX localparam (=WORDS)
  - the default width constants shared with RegisterFile.
- One sub-module, reg_dump_cksum. It is the clear/accumulate register, instantiated only under DUMP_CHECKSUM_EN.

## Test plan
- Preload reg[i]=32'h1000_0000+i, ready=1, halted_i tied 1, pulse start -> 32 words in order, idx 0..31, done_o after 67 cycles (68 with checksum). Checksum=32'h0000_01F0 (32*32'h1000_0000 wraps to 0; plus 496).
- halted_i delayed 5 cycles -> halt_o high throughout, no dout_valid_o until 2 cycles after halted_i.
- Random dout_ready_i backpressure -> dout_o/dout_idx_o stable while valid&&!ready, no word lost or duplicated.
- abort_i during idx=7 PRESENT -> next cycle IDLE, halt_o=0, valid=0, no done_o. A new start restarts at idx 0 with a fresh checksum.
- rst_ni low mid-dump at idx=20 -> all outputs at reset values on the next edge.
- start_i pulses while busy -> ignored; exactly one dump of WORDS words.

Source files
------------

// File: rtl/reg_dump_pkg.sv
// Shared types and default widths for the register-file dump reader.
// Widths match the 32x32 register file the reader walks.
package reg_dump_pkg;

    localparam int REG_DATA_WIDTH  = 32;
    localparam int REG_SELECT_SIZE = 5;
    localparam int REG_WORDS       = 1 << REG_SELECT_SIZE;

    // Index value tagging the trailing checksum word on the stream.
    localparam int CKSUM_IDX = REG_WORDS;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HALT,
        ST_FETCH,
        ST_PRESENT,
        ST_CKSUM,
        ST_DONE
    } state_e;

endpackage

// File: rtl/reg_dump_cksum.sv
// Clear/accumulate register holding the running sum of streamed words
// (modulo 2**DATA_WIDTH). Used only when DUMP_CHECKSUM_EN is defined.
module reg_dump_cksum
    import reg_dump_pkg::*;
#(
    parameter int DATA_WIDTH = REG_DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clr_i,
    input  logic                  add_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] sum_o
);

    logic [DATA_WIDTH-1:0] sum_d, sum_q;

    always_comb begin
        sum_d = sum_q;
        if (clr_i) begin
            sum_d = '0;
        end else if (add_i) begin
            sum_d = sum_q + data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/reg_dump_reader.sv
// Debug read-out sequencer: halts the core, walks the register file through
// the srcA port and streams every word over valid/ready. Macro DUMP_CHECKSUM_EN
// appends a checksum word (index WORDS) after the last register.
module reg_dump_reader
    import reg_dump_pkg::*;
#(
    parameter int DATA_WIDTH  = REG_DATA_WIDTH,
    parameter int WORDS       = REG_WORDS,
    parameter int SELECT_SIZE = REG_SELECT_SIZE
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic                   abort_i,
    output logic                   halt_o,
    input  logic                   halted_i,
    output logic [SELECT_SIZE-1:0] reg_sel_o,
    input  logic [DATA_WIDTH-1:0]  reg_data_i,
    output logic [DATA_WIDTH-1:0]  dout_o,
    output logic [SELECT_SIZE:0]   dout_idx_o,
    output logic                   dout_valid_o,
    input  logic                   dout_ready_i,
    output logic                   busy_o,
    output logic                   done_o
);

    localparam logic [SELECT_SIZE-1:0] LAST_IDX = SELECT_SIZE'(WORDS - 1);

    state_e                 state_d, state_q;
    logic [SELECT_SIZE-1:0] idx_d, idx_q;
    logic [SELECT_SIZE-1:0] reg_sel_d, reg_sel_q;
    logic [DATA_WIDTH-1:0]  dout_d, dout_q;
    logic [SELECT_SIZE:0]   dout_idx_d, dout_idx_q;
    logic                   valid_d, valid_q;
    logic                   halt_d, halt_q;
    logic                   busy_d, busy_q;
    logic                   done_d, done_q;
    logic                   xfer;

`ifdef DUMP_CHECKSUM_EN
    logic                  cks_clr, cks_add;
    logic [DATA_WIDTH-1:0] cks_sum;

    reg_dump_cksum #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_cksum (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .clr_i (cks_clr),
        .add_i (cks_add),
        .data_i(dout_q),
        .sum_o (cks_sum)
    );
`endif

    assign xfer = valid_q && dout_ready_i;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        dout_d     = dout_q;
        dout_idx_d = dout_idx_q;
        valid_d    = valid_q;
`ifdef DUMP_CHECKSUM_EN
        cks_clr    = 1'b0;
        cks_add    = 1'b0;
`endif

        // Abort wins over everything, including a transfer in the same cycle.
        if (abort_i && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_d = ST_HALT;
                        idx_d   = '0;
`ifdef DUMP_CHECKSUM_EN
                        cks_clr = 1'b1;
`endif
                    end
                end
                ST_HALT: begin
                    if (halted_i) state_d = ST_FETCH;
                end
                ST_FETCH: begin
                    dout_d     = reg_data_i;
                    dout_idx_d = {1'b0, idx_q};
                    valid_d    = 1'b1;
                    state_d    = ST_PRESENT;
                end
                ST_PRESENT: begin
                    if (xfer) begin
                        valid_d = 1'b0;
`ifdef DUMP_CHECKSUM_EN
                        cks_add = 1'b1;
`endif
                        if (idx_q == LAST_IDX) begin
`ifdef DUMP_CHECKSUM_EN
                            // Accumulator updates on this same edge, so fold the last word in here.
                            state_d    = ST_CKSUM;
                            dout_d     = cks_sum + dout_q;
                            dout_idx_d = (SELECT_SIZE + 1)'(WORDS);
                            valid_d    = 1'b1;
`else
                            state_d = ST_DONE;
`endif
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = ST_FETCH;
                        end
                    end
                end
`ifdef DUMP_CHECKSUM_EN
                ST_CKSUM: begin
                    if (xfer) begin
                        valid_d = 1'b0;
                        state_d = ST_DONE;
                    end
                end
`endif
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end

        halt_d    = (state_d != ST_IDLE);
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_DONE);
        reg_sel_d = (state_d == ST_FETCH) ? idx_d : reg_sel_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            reg_sel_q  <= '0;
            dout_q     <= '0;
            dout_idx_q <= '0;
            valid_q    <= 1'b0;
            halt_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            reg_sel_q  <= reg_sel_d;
            dout_q     <= dout_d;
            dout_idx_q <= dout_idx_d;
            valid_q    <= valid_d;
            halt_q     <= halt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign halt_o       = halt_q;
    assign reg_sel_o    = reg_sel_q;
    assign dout_o       = dout_q;
    assign dout_idx_o   = dout_idx_q;
    assign dout_valid_o = valid_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule
